// File: rtl/rat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rat_pkg
// Brief    : Shared geometry, types and snapshot record for the rename table.
// Revision : 1.0
// ============================================================================
package rat_pkg;

  localparam int NUM_ARCH_REGS   = 32;
  localparam int AREG_WIDTH      = 5;
  localparam int DATA_WIDTH      = 32;
  localparam int ROB_ENTRY_WIDTH = 8;
  localparam int NUM_READ_PORTS  = 2;
  localparam int CKPT_NUM        = 4;
  localparam int CKPT_WIDTH      = 2;

  typedef logic [AREG_WIDTH-1:0]      areg_t;
  typedef logic [ROB_ENTRY_WIDTH-1:0] rob_tag_t;
  typedef logic [CKPT_WIDTH-1:0]      ckpt_id_t;

  typedef struct packed {
    logic     [NUM_ARCH_REGS-1:0] busy;
    rob_tag_t [NUM_ARCH_REGS-1:0] tag;
  } rat_snap_t;

endpackage
`default_nettype wire

// File: rtl/rat_ckpt_store.sv
`default_nettype none
// ============================================================================
// Module   : rat_ckpt_store
// Brief    : FIFO of busy/tag snapshots with head/tail/count and commit clear.
// Revision : 1.0
// ============================================================================
module rat_ckpt_store
  import rat_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_take,
  input  logic                       i_release,
  input  logic                       i_rollback,
  input  logic [CKPT_WIDTH-1:0]      i_rb_id,
  input  logic                       i_flush,
  input  logic                       i_cm_en,
  input  logic [AREG_WIDTH-1:0]      i_cm_addr,
  input  logic [ROB_ENTRY_WIDTH-1:0] i_cm_tag,
  input  rat_snap_t                  i_snap,
  output rat_snap_t                  o_rb_snap,
  output logic [CKPT_WIDTH-1:0]      o_ckpt_id,
  output logic                       o_ckpt_full
);

  localparam logic [CKPT_WIDTH:0] C_FULL = (CKPT_WIDTH+1)'(CKPT_NUM);

  ckpt_id_t              r_head;
  ckpt_id_t              r_tail;
  logic [CKPT_WIDTH:0]   r_count;
  rat_snap_t             r_slot [CKPT_NUM];

  logic                  w_rel;
  logic                  w_take;
  ckpt_id_t              w_head_n;
  ckpt_id_t              w_rb_tail;
  logic [CKPT_WIDTH:0]   w_rb_count;
  logic [CKPT_WIDTH:0]   w_cnt_n;
  logic [CKPT_NUM-1:0]   w_live;

  assign o_ckpt_full = (r_count == C_FULL);
  assign o_ckpt_id   = r_tail;
  assign o_rb_snap   = r_slot[i_rb_id];

  assign w_rel     = i_release && (r_count != '0);
  assign w_take    = i_take && !o_ckpt_full;
  assign w_head_n  = r_head + ckpt_id_t'(w_rel);
  assign w_rb_tail = i_rb_id + ckpt_id_t'(1);
  assign w_cnt_n   = r_count - (CKPT_WIDTH+1)'(w_rel) + (CKPT_WIDTH+1)'(w_take);

  // tail==head after rollback is ambiguous: only rb_id one behind the
  // pre-release head means every slot stays live.
  always_comb begin
    w_rb_count = '0;
    if (w_rb_tail != w_head_n)
      w_rb_count = {1'b0, ckpt_id_t'(w_rb_tail - w_head_n)};
    else if (i_rb_id == ckpt_id_t'(r_head - ckpt_id_t'(1)))
      w_rb_count = C_FULL;
  end

  always_comb begin
    w_live = '0;
    for (int i = 0; i < CKPT_NUM; i++)
      w_live[i] = ({1'b0, ckpt_id_t'(ckpt_id_t'(i) - r_head)} < r_count);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < CKPT_NUM; i++)
        r_slot[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < CKPT_NUM; i++) begin
        if (w_live[i] && i_cm_en && r_slot[i].busy[i_cm_addr] &&
            (r_slot[i].tag[i_cm_addr] == i_cm_tag)) begin
          r_slot[i].busy[i_cm_addr] <= 1'b0;
          r_slot[i].tag[i_cm_addr]  <= '0;
        end
      end
      r_head <= w_head_n;
      if (i_rollback) begin
        r_tail  <= w_rb_tail;
        r_count <= w_rb_count;
      end else begin
        if (w_take) begin
          r_slot[r_tail] <= i_snap;
          r_tail         <= r_tail + ckpt_id_t'(1);
        end
        r_count <= w_cnt_n;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rat_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : rat_ckpt
// Brief    : Register alias table with branch checkpoints and one-cycle restore.
//            Optional macro RAT_COMMIT_BYPASS_EN forwards commits to reads.
// Revision : 1.0
// ============================================================================
module rat_ckpt
  import rat_pkg::*;
#(
  parameter int NUM_READ_PORTS = rat_pkg::NUM_READ_PORTS,
  parameter int DATA_WIDTH     = rat_pkg::DATA_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_READ_PORTS*AREG_WIDTH-1:0]      raddr,
  output logic [NUM_READ_PORTS-1:0]                 rvalid,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]      rdata,
  output logic [NUM_READ_PORTS*ROB_ENTRY_WIDTH-1:0] rrob_idx,
  input  logic                                      dec_we,
  input  logic [AREG_WIDTH-1:0]                     dec_waddr,
  input  logic [ROB_ENTRY_WIDTH-1:0]                dec_rob_idx,
  input  logic                                      cm_we,
  input  logic [AREG_WIDTH-1:0]                     cm_addr,
  input  logic [DATA_WIDTH-1:0]                     cm_data,
  input  logic [ROB_ENTRY_WIDTH-1:0]                cm_rob_idx,
  input  logic                                      ckpt_take,
  output logic [CKPT_WIDTH-1:0]                     ckpt_id,
  output logic                                      ckpt_full,
  input  logic                                      ckpt_release,
  input  logic                                      rollback,
  input  logic [CKPT_WIDTH-1:0]                     rb_id,
  input  logic                                      flush
);

  logic     [NUM_ARCH_REGS-1:0]                 r_valid;
  rob_tag_t [NUM_ARCH_REGS-1:0]                 r_tag;
  logic     [NUM_ARCH_REGS-1:0][DATA_WIDTH-1:0] r_value;

  logic      w_cm_en;
  logic      w_ren_en;
  logic      w_take;
  rat_snap_t w_live_snap;
  rat_snap_t w_rb_raw;
  rat_snap_t w_rb_snap;

  assign w_cm_en  = cm_we && (cm_addr != '0);
  assign w_ren_en = dec_we && (dec_waddr != '0);
  assign w_take   = ckpt_take && !rollback && !flush;

  // Rename is applied after the commit clear so it wins on the same register.
  always_comb begin
    w_live_snap.busy    = ~r_valid;
    w_live_snap.tag     = r_tag;
    w_live_snap.busy[0] = 1'b0;
    if (w_cm_en && !r_valid[cm_addr] && (r_tag[cm_addr] == cm_rob_idx)) begin
      w_live_snap.busy[cm_addr] = 1'b0;
      w_live_snap.tag[cm_addr]  = '0;
    end
    if (w_ren_en) begin
      w_live_snap.busy[dec_waddr] = 1'b1;
      w_live_snap.tag[dec_waddr]  = dec_rob_idx;
    end
    w_rb_snap         = w_rb_raw;
    w_rb_snap.busy[0] = 1'b0;
    if (w_cm_en && w_rb_raw.busy[cm_addr] && (w_rb_raw.tag[cm_addr] == cm_rob_idx)) begin
      w_rb_snap.busy[cm_addr] = 1'b0;
      w_rb_snap.tag[cm_addr]  = '0;
    end
  end

  rat_ckpt_store u_store (
    .clk         (clk),
    .rst         (rst),
    .i_take      (w_take),
    .i_release   (ckpt_release),
    .i_rollback  (rollback),
    .i_rb_id     (rb_id),
    .i_flush     (flush),
    .i_cm_en     (w_cm_en),
    .i_cm_addr   (cm_addr),
    .i_cm_tag    (cm_rob_idx),
    .i_snap      (w_live_snap),
    .o_rb_snap   (w_rb_raw),
    .o_ckpt_id   (ckpt_id),
    .o_ckpt_full (ckpt_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '1;
      r_tag   <= '0;
      r_value <= '0;
    end else begin
      if (w_cm_en)
        r_value[cm_addr] <= cm_data;
      if (flush) begin
        r_valid <= '1;
        r_tag   <= '0;
      end else if (rollback) begin
        r_valid <= ~w_rb_snap.busy;
        r_tag   <= w_rb_snap.tag;
      end else begin
        r_valid <= ~w_live_snap.busy;
        r_tag   <= w_live_snap.tag;
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [AREG_WIDTH-1:0] w_a;
    logic                  w_v;
    logic [DATA_WIDTH-1:0] w_d;
    rob_tag_t              w_t;

    assign w_a = raddr[p*AREG_WIDTH +: AREG_WIDTH];

    always_comb begin
      w_v = r_valid[w_a];
      w_d = r_value[w_a];
      w_t = r_tag[w_a];
      if (w_a == '0) begin
        w_v = 1'b1;
        w_d = '0;
        w_t = '0;
      end
`ifdef RAT_COMMIT_BYPASS_EN
      else if (w_cm_en && (cm_addr == w_a) && !r_valid[w_a] &&
               (r_tag[w_a] == cm_rob_idx)) begin
        w_v = 1'b1;
        w_d = cm_data;
        w_t = '0;
      end
`endif
    end

    assign rvalid[p]                                      = w_v;
    assign rdata[p*DATA_WIDTH +: DATA_WIDTH]              = w_d;
    assign rrob_idx[p*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH] = w_t;
  end

endmodule
`default_nettype wire
